// File: rtl/dnn_pkg.sv
// dnn_pkg: shared state encodings, storage-format conversion and layout helpers
// for the dense-layer weight RAM.
package dnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CSUM = 2'd2,
        DONE = 2'd3
    } loader_state_t;

    // RAM holds weights in offset binary; the dense-layer reader flips bit 7 back.
    function automatic logic [7:0] to_offset_bin(input logic [7:0] b);
        return {~b[7], b[6:0]};
    endfunction

    function automatic int matrix_size(input int n, input int m);
        return n * m;
    endfunction

    function automatic int param_size(input int n, input int m);
        return n * m + m;
    endfunction

endpackage

// File: rtl/dnn_weight_addr_gen.sv
// dnn_weight_addr_gen: payload counters and RAM write address for both stream orders.
// The transposed address is built by stepping N per inner count, so no multiplier is needed.
module dnn_weight_addr_gen
    import dnn_pkg::*;
#(
    parameter int N           = 64,
    parameter int M           = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int BASE_ADDR   = 0,
    parameter int INPUT_MAJOR = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);
    localparam logic [ADDR_WIDTH-1:0] MATRIX_SIZE = ADDR_WIDTH'(matrix_size(N, M));
    localparam logic [ADDR_WIDTH-1:0] K_LAST      = ADDR_WIDTH'(param_size(N, M) - 1);
    localparam logic [ADDR_WIDTH-1:0] J_LAST      = ADDR_WIDTH'(M - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE      = ADDR_WIDTH'(N);
    localparam logic [ADDR_WIDTH-1:0] BASE        = ADDR_WIDTH'(BASE_ADDR);

    logic [ADDR_WIDTH-1:0] k, i, j, t;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            k <= '0;
            i <= '0;
            j <= '0;
            t <= '0;
        end else if (advance) begin
            k <= k + 1'b1;
            if (j == J_LAST) begin
                j <= '0;
                i <= i + 1'b1;
                t <= i + 1'b1;
            end else begin
                j <= j + 1'b1;
                t <= t + STRIDE;
            end
        end
    end

    // Bias bytes follow the matrix linearly in either stream order.
    always_comb begin
        addr = (INPUT_MAJOR != 0 && k < MATRIX_SIZE) ? BASE + t : BASE + k;
        last = (k == K_LAST);
    end

endmodule

// File: rtl/dnn_weight_loader.sv
// dnn_weight_loader: streams signed weight bytes into the dense-layer RAM in
// offset binary and verifies the trailing 16-bit checksum.
module dnn_weight_loader
    import dnn_pkg::*;
#(
    parameter int N           = 64,
    parameter int M           = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int BASE_ADDR   = 0,
    parameter int INPUT_MAJOR = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_din,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    loader_state_t         state, nxt;
    logic                  accept, go, pay, last, csum_hi;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           csum;
    logic [7:0]            rx_lo;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt     = state;
        s_ready = 1'b0;
        busy    = 1'b0;
        go      = 1'b0;
        case (state)
            IDLE, DONE: begin
                go  = start;
                nxt = start ? LOAD : state;
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                nxt     = (s_valid && last) ? CSUM : LOAD;
            end
            CSUM: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                nxt     = (s_valid && csum_hi) ? DONE : CSUM;
            end
            default: nxt = IDLE;
        endcase
        accept = s_valid && s_ready;
        pay    = accept && state == LOAD;
    end

    dnn_weight_addr_gen #(
        .N          (N),
        .M          (M),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .INPUT_MAJOR(INPUT_MAJOR)
    ) u_addr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (go),
        .advance(pay),
        .addr   (addr),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            csum     <= '0;
            rx_lo    <= '0;
            csum_hi  <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            mem_we <= pay;
            if (pay) begin
                mem_addr <= addr;
                mem_din  <= to_offset_bin(s_data);
                csum     <= csum + {{8{s_data[7]}}, s_data};
            end
            if (go) begin
                csum    <= '0;
                csum_hi <= 1'b0;
                done    <= 1'b0;
                error   <= 1'b0;
            end
            // Received checksum arrives low byte first.
            if (accept && state == CSUM) begin
                csum_hi <= 1'b1;
                if (!csum_hi) begin
                    rx_lo <= s_data;
                end else begin
                    done  <= 1'b1;
                    error <= csum != {s_data, rx_lo};
                end
            end
        end
    end

endmodule

// File: tb/tb_dnn_weight_loader.sv
// tb_dnn_weight_loader: scoreboard bench driving a row-major and a transposed
// loader (N=4, M=2) from one shared byte stream.
module tb_dnn_weight_loader;
    logic        clk = 0, rst_n = 0, start = 0, s_valid = 0;
    logic [7:0]  s_data = 0;
    logic        s_ready0, mem_we0, busy0, done0, error0;
    logic        s_ready1, mem_we1, busy1, done1, error1;
    logic [11:0] mem_addr0, mem_addr1;
    logic [7:0]  mem_din0, mem_din1;
    int          n_checks = 0, n_fail = 0;

    typedef struct { logic [11:0] a; logic [7:0] d; } exp_t;
    exp_t q0[$], q1[$];

    always #5 clk = ~clk;

    dnn_weight_loader #(.N(4), .M(2), .ADDR_WIDTH(12), .BASE_ADDR(0), .INPUT_MAJOR(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_din(mem_din0),
        .busy(busy0), .done(done0), .error(error0));

    dnn_weight_loader #(.N(4), .M(2), .ADDR_WIDTH(12), .BASE_ADDR(0), .INPUT_MAJOR(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_din(mem_din1),
        .busy(busy1), .done(done1), .error(error1));

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mem_we0) begin
            if (q0.size() == 0) chk("wr0_unexpected", 1, 0);
            else begin
                e = q0.pop_front();
                chk("wr0_addr", {20'd0, mem_addr0}, {20'd0, e.a});
                chk("wr0_data", {24'd0, mem_din0}, {24'd0, e.d});
            end
        end
        if (mem_we1) begin
            if (q1.size() == 0) chk("wr1_unexpected", 1, 0);
            else begin
                e = q1.pop_front();
                chk("wr1_addr", {20'd0, mem_addr1}, {20'd0, e.a});
                chk("wr1_data", {24'd0, mem_din1}, {24'd0, e.d});
            end
        end
    end

    logic [11:0] tr_addr [10] = '{0, 4, 1, 5, 2, 6, 3, 7, 8, 9};
    logic [7:0]  seq_d   [10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    logic [7:0]  seq_o   [10] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89};
    logic [7:0]  sgn_d   [10] = '{8'h80, 8'hFF, 8'h00, 8'h7F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    logic [7:0]  sgn_o   [10] = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86};

    task automatic put(input logic [7:0] d, input int gapmax);
        repeat ($urandom_range(0, gapmax)) begin
            @(negedge clk);
            s_valid = 0;
            start   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start = 0;
        chk("s_ready", {31'd0, s_ready0}, 1);
        s_valid = 1;
        s_data  = d;
    endtask

    task automatic begin_load;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("busy_after_start", {30'd0, busy1, busy0}, 3);
        chk("done_cleared", {30'd0, done1, done0}, 0);
        chk("error_cleared", {30'd0, error1, error0}, 0);
    endtask

    task automatic load(input logic [7:0] d [10], input logic [7:0] o [10],
                        input logic [7:0] c0, input logic [7:0] c1,
                        input logic exp_err, input int gapmax);
        begin_load();
        for (int k = 0; k < 10; k++) begin
            q0.push_back('{12'(k), o[k]});
            q1.push_back('{tr_addr[k], o[k]});
            put(d[k], gapmax);
        end
        put(c0, gapmax);
        put(c1, gapmax);
        @(negedge clk);
        s_valid = 0;
        chk("done", {30'd0, done1, done0}, 3);
        chk("error", {30'd0, error1, error0}, {30'd0, exp_err, exp_err});
        chk("busy_end", {30'd0, busy1, busy0}, 0);
        chk("s_ready_end", {31'd0, s_ready0}, 0);
        repeat (2) @(negedge clk);
        chk("addr_hold", {20'd0, mem_addr0}, 9);
        chk("din_hold", {24'd0, mem_din0}, {24'd0, o[9]});
        chk("done_held", {31'd0, done0}, 1);
        chk("queue_drained", q0.size() + q1.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, {30'd0, s_ready1, s_ready0}, 0);
        chk({tag, "_mem_we"}, {30'd0, mem_we1, mem_we0}, 0);
        chk({tag, "_mem_addr"}, {8'd0, mem_addr1, mem_addr0}, 0);
        chk({tag, "_mem_din"}, {16'd0, mem_din1, mem_din0}, 0);
        chk({tag, "_busy"}, {30'd0, busy1, busy0}, 0);
        chk({tag, "_done"}, {30'd0, done1, done0}, 0);
        chk({tag, "_error"}, {30'd0, error1, error0}, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1;
        @(negedge clk);
        chk_reset_outputs("idle");

        load(seq_d, seq_o, 8'h2D, 8'h00, 1'b0, 0);
        load(seq_d, seq_o, 8'h2E, 8'h00, 1'b1, 0);
        load(sgn_d, sgn_o, 8'h13, 8'h00, 1'b0, 0);
        load(seq_d, seq_o, 8'h2D, 8'h00, 1'b0, 3);

        begin_load();
        for (int k = 0; k < 5; k++) begin
            q0.push_back('{12'(k), seq_o[k]});
            q1.push_back('{tr_addr[k], seq_o[k]});
            put(seq_d[k], 0);
        end
        @(negedge clk);
        s_valid = 0;
        rst_n   = 0;
        @(negedge clk);
        chk_reset_outputs("midload_reset");
        chk("midload_drained", q0.size() + q1.size(), 0);
        rst_n = 1;
        load(seq_d, seq_o, 8'h2D, 8'h00, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
